// File: rtl/hex_sum_pkg.sv
// Shared constants and FSM encoding for the hex digit-sum circuit and its
// inverse builder.
package hex_sum_pkg;

   localparam int unsigned DIGIT_MAX  = 15;
   localparam int unsigned NUM_DIGITS = 8;
   localparam int unsigned MAX_SUM    = DIGIT_MAX * NUM_DIGITS;

   typedef enum logic {
      IDLE  = 1'b0,
      BUILD = 1'b1
   } state_e;

endpackage

// File: rtl/hex_digit_sel.sv
// Picks the next hex digit from the remaining sum: the largest digit that
// still fits, plus the remainder left after emitting it.
module hex_digit_sel
   import hex_sum_pkg::*;
#(
   parameter int unsigned SUM_W = 7
) (
   input  logic [SUM_W-1:0] rem,
   output logic [3:0]       d,
   output logic [SUM_W-1:0] rem_next,
   output logic             last
);

   always_comb begin
      d        = (rem > SUM_W'(DIGIT_MAX)) ? 4'(DIGIT_MAX) : rem[3:0];
      rem_next = rem - SUM_W'(d);
      last     = (rem_next == '0);
   end

endmodule

// File: rtl/hex_num_from_digit_sum.sv
// Serially builds the smallest number whose hex digits sum to target,
// one digit per clock, least significant digit first.
module hex_num_from_digit_sum #(
   parameter int unsigned NUM_DIGITS = hex_sum_pkg::NUM_DIGITS,
   parameter int unsigned SUM_W      = 7
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [SUM_W-1:0]        target,
   output logic [4*NUM_DIGITS-1:0] num,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);

   import hex_sum_pkg::*;

   localparam int unsigned     IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [SUM_W-1:0] MAX_S = SUM_W'(DIGIT_MAX * NUM_DIGITS);

   state_e                  state_q, state_d;
   logic [SUM_W-1:0]        rem_q, rem_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] num_q, num_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;

   logic [3:0]              dig;
   logic [SUM_W-1:0]        rem_next;
   logic                    last;

   hex_digit_sel #(
      .SUM_W(SUM_W)
   ) u_sel (
      .rem     (rem_q),
      .d       (dig),
      .rem_next(rem_next),
      .last    (last)
   );

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      idx_d   = idx_q;
      num_d   = num_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               num_d = '0;
               if (target > MAX_S) begin
                  err_d  = 1'b1;
                  done_d = 1'b1;
               end else begin
                  rem_d   = target;
                  idx_d   = '0;
                  err_d   = 1'b0;
                  busy_d  = 1'b1;
                  state_d = BUILD;
               end
            end
         end
         BUILD: begin
            num_d[4*idx_q +: 4] = dig;
            rem_d = rem_next;
            idx_d = idx_q + 1'b1;
            // The top digit ends the build even if rem is nonzero; target
            // is range-checked on entry so that cannot lose any sum.
            if (last || (idx_q == IDX_W'(NUM_DIGITS - 1))) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         idx_q   <= '0;
         num_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         idx_q   <= idx_d;
         num_q   <= num_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign num  = num_q;
   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;

endmodule

// File: tb/tb_hex_num_from_digit_sum.sv
// Scoreboard bench for hex_num_from_digit_sum: requests push the expected
// result, a monitor pops and checks it whenever done pulses.
module tb_hex_num_from_digit_sum;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [6:0]  target;
   logic [31:0] num;
   logic        busy, done, err;

   hex_num_from_digit_sum #(
      .NUM_DIGITS(8),
      .SUM_W     (7)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .target(target),
      .num   (num),
      .busy  (busy),
      .done  (done),
      .err   (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          s;
      logic [31:0] num;
      logic        err;
      int          acc;
      int          lat;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Closed form: D-1 low digits of F, then the leftover, upper digits zero.
   function automatic logic [31:0] min_num(input int s);
      int          dn;
      logic [63:0] v;
      dn = (s == 0) ? 1 : (s + 14) / 15;
      v  = (64'd1 << (4 * (dn - 1))) - 64'd1;
      v  = v | (64'(s - 15 * (dn - 1)) << (4 * (dn - 1)));
      return v[31:0];
   endfunction

   function automatic int hex_digit_sum(input logic [31:0] v);
      int sum = 0;
      for (int i = 0; i < 8; i++) sum += int'((v >> (4 * i)) & 32'hF);
      return sum;
   endfunction

   always @(negedge clk) begin
      if (!rst && done) begin
         if (q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check($sformatf("num S=%0d", e.s), num, e.num);
            check($sformatf("err S=%0d", e.s), err, e.err);
            check($sformatf("latency S=%0d", e.s), cyc - e.acc, e.lat);
            check($sformatf("busy_at_done S=%0d", e.s), busy, 0);
            if (!e.err) check($sformatf("loopback S=%0d", e.s), hex_digit_sum(num), e.s);
         end
      end
   end

   task automatic wait_done();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) return;
      end
      check("done_timeout", 0, 1);
      q.delete();
   endtask

   task automatic issue(input int s, input bit wait_for_done);
      exp_t e;
      logic [6:0] t;
      t = 7'(s);
      @(negedge clk);
      start  = 1'b1;
      target = t;
      @(posedge clk);
      #1;
      start = 1'b0;
      e.s   = s;
      e.err = (s > 120);
      e.num = (s > 120) ? 32'h0 : min_num(s);
      e.acc = cyc;
      e.lat = (s > 120) ? 0 : ((s == 0) ? 1 : (s + 14) / 15);
      q.push_back(e);
      check($sformatf("busy_after_accept S=%0d", s), busy, (s <= 120));
      if (wait_for_done) wait_done();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      target = '0;
      #3;
      check("reset_num", num, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_err", err, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      issue(35, 1);
      issue(0, 1);
      issue(15, 1);
      issue(16, 1);
      issue(120, 1);
      issue(121, 1);
      @(negedge clk);
      check("err_holds", err, 1);
      check("done_single_pulse", done, 0);
      issue(127, 1);

      // Reset part-way through a full-length build.
      issue(120, 0);
      repeat (4) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("midrst_num", num, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_err", err, 0);
      q.delete();
      #2;
      rst = 1'b0;
      issue(47, 1);

      // start toggled while building must be ignored.
      issue(60, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         start  = ~start;
         target = 7'($urandom_range(127, 0));
      end
      @(negedge clk);
      start = 1'b0;
      wait_done();

      for (int s = 0; s <= 120; s++) issue(s, 1);
      for (int i = 0; i < 40; i++) issue(int'($urandom_range(127, 0)), 1);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
